// File: rtl/local_packet_source.sv
// local_packet_source
//   Local-node traffic injector for a mesh router node. It accepts a packet
//   descriptor, then emits one header flit {length, dest} followed by `length`
//   body flits. Body flit i carries req_seed + i (mod 2^16). A flit is offered
//   only while the router's local input FIFO is not full.
//
// Parameters
//   NODE_X, NODE_Y : coordinates of this node; LOCAL_ADDR = {NODE_X[3:0], NODE_Y[3:0]}
//   MAX_LEN        : largest body length emitted; longer requests are clamped
//
// Ports
//   clk, rst       : clock (rising edge) and synchronous active-high reset
//   req_valid/ready: descriptor handshake; ready only while idle
//   req_dest       : destination {x[3:0], y[3:0]}
//   req_length     : body flit count (0 = header-only packet)
//   req_seed       : payload of body flit 0
//   buffer_full    : router local FIFO full; blocks transfers
//   sending_data   : data_out transfers this cycle
//   data_out       : flit, zero whenever sending_data is low
//   busy           : packet in progress
//   pkt_done       : one-cycle pulse after the last flit transfers
//   req_err        : one-cycle pulse when a self-addressed request is dropped
//   pkt_count      : completed packets (statistics build only, else 0)
//   stall_count    : backpressure cycles (statistics build only, else 0)
//
// Build option
//   LOCAL_PACKET_SOURCE_STATS_EN : when defined, pkt_count and stall_count are
//   live saturating counters; otherwise both ports are tied to zero.

module local_packet_source #(
  parameter int unsigned NODE_X  = 0,
  parameter int unsigned NODE_Y  = 0,
  parameter int unsigned MAX_LEN = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_dest,
  input  logic [7:0]  req_length,
  input  logic [15:0] req_seed,
  input  logic        buffer_full,
  output logic        sending_data,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        pkt_done,
  output logic        req_err,
  output logic [15:0] pkt_count,
  output logic [15:0] stall_count
);

  localparam logic [7:0] LocalAddr = {4'(NODE_X), 4'(NODE_Y)};
  localparam logic [7:0] MaxLen    = 8'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [7:0]  r_dest;
  logic [7:0]  r_len;
  logic [7:0]  r_remain;
  logic [15:0] r_payload;
  logic        r_pkt_done;
  logic        r_req_err;

  logic        w_accept;
  logic        w_self;
  logic        w_xfer;
  logic        w_last;
  logic [7:0]  w_len_clamped;

  assign w_accept      = req_valid && (r_state == StIdle);
  assign w_self        = (req_dest == LocalAddr);
  // Any non-idle state offers a flit; it moves only when the FIFO has room.
  assign w_xfer        = (r_state != StIdle) && !buffer_full;
  assign w_last        = w_xfer && (((r_state == StHead) && (r_len == 8'd0)) ||
                                    ((r_state == StBody) && (r_remain == 8'd1)));
  assign w_len_clamped = (req_length > MaxLen) ? MaxLen : req_length;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept && !w_self) w_state_next = StHead;
      end
      StHead: begin
        if (w_xfer) w_state_next = (r_len == 8'd0) ? StIdle : StBody;
      end
      StBody: begin
        if (w_xfer && (r_remain == 8'd1)) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready    = (r_state == StIdle);
    busy         = (r_state != StIdle);
    sending_data = w_xfer;
    data_out     = 16'h0000;
    if (w_xfer) begin
      data_out = (r_state == StHead) ? {r_len, r_dest} : r_payload;
    end
  end

  // Descriptor and flit datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest     <= 8'h00;
      r_len      <= 8'h00;
      r_remain   <= 8'h00;
      r_payload  <= 16'h0000;
      r_pkt_done <= 1'b0;
      r_req_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dest    <= req_dest;
        r_len     <= w_len_clamped;
        r_payload <= req_seed;
      end
      if ((r_state == StHead) && w_xfer) begin
        r_remain <= r_len;
      end
      if ((r_state == StBody) && w_xfer) begin
        r_payload <= r_payload + 16'd1;
        r_remain  <= r_remain - 8'd1;
      end
      r_pkt_done <= w_last;
      r_req_err  <= w_accept && w_self;
    end
  end

  assign pkt_done = r_pkt_done;
  assign req_err  = r_req_err;

`ifdef LOCAL_PACKET_SOURCE_STATS_EN
  logic [15:0] r_pkt_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_count   <= 16'h0000;
      r_stall_count <= 16'h0000;
    end else begin
      if (w_last && (r_pkt_count != 16'hFFFF)) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      if ((r_state != StIdle) && buffer_full && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign pkt_count   = r_pkt_count;
  assign stall_count = r_stall_count;
`else
  assign pkt_count   = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_local_packet_source.sv
// Bench for local_packet_source at node (1,2). Expected flits (data and cycle)
// are queued when a request is accepted and compared as the DUT transfers them.

module tb_local_packet_source;

  localparam int unsigned NodeX  = 1;
  localparam int unsigned NodeY  = 2;
  localparam int unsigned MaxLen = 255;
  localparam logic [7:0]  LocalAddr = 8'h12;
`ifdef LOCAL_PACKET_SOURCE_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_dest;
  logic [7:0]  req_length;
  logic [15:0] req_seed;
  logic        buffer_full;
  logic        sending_data;
  logic [15:0] data_out;
  logic        busy;
  logic        pkt_done;
  logic        req_err;
  logic [15:0] pkt_count;
  logic [15:0] stall_count;

  local_packet_source #(
    .NODE_X (NodeX),
    .NODE_Y (NodeY),
    .MAX_LEN(MaxLen)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dest    (req_dest),
    .req_length  (req_length),
    .req_seed    (req_seed),
    .buffer_full (buffer_full),
    .sending_data(sending_data),
    .data_out    (data_out),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .req_err     (req_err),
    .pkt_count   (pkt_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Flit monitor
  always @(negedge clk) begin
    if (buffer_full) check_val("no_flit_when_full", 32'(sending_data), 32'd0);
    if (sending_data) begin
      if (sb.size() == 0) begin
        check_val("unexpected_flit", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("flit_data", 32'(data_out), 32'(mon_e.data));
        check_val("flit_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      check_val("idle_data_zero", 32'(data_out), 32'd0);
    end
  end

  // Land on the falling edge of cycle k.
  task automatic at_cyc(input int k);
    do @(negedge clk); while (cyc < k);
  endtask

  // Holds the descriptor until accepted; returns the cycle of acceptance, in
  // which the header is expected. stall = planned backpressure cycles after the header.
  task automatic issue(input logic [7:0] dest, input logic [7:0] len, input logic [15:0] seed,
                       input int stall, output int t);
    bit   acc;
    int   n;
    int   l;
    exp_t e;
    req_valid  = 1'b1;
    req_dest   = dest;
    req_length = len;
    req_seed   = seed;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    t = cyc;
    req_valid = 1'b0;
    check_val("accept_timeout", 32'(acc), 32'd1);
    if (dest != LocalAddr) begin
      l = (int'(len) > int'(MaxLen)) ? int'(MaxLen) : int'(len);
      e.data = {l[7:0], dest};
      e.cyc  = t;
      sb.push_back(e);
      for (int i = 0; i < l; i++) begin
        e.data = seed + 16'(i);
        e.cyc  = t + 1 + i + stall;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t2;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_dest    = 8'h00;
    req_length  = 8'h00;
    req_seed    = 16'h0000;
    buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_pkt_done", 32'(pkt_done), 32'd0);
    check_val("rst_req_err", 32'(req_err), 32'd0);
    check_val("rst_pkt_count", 32'(pkt_count), 32'd0);
    check_val("rst_stall_count", 32'(stall_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic packet, no backpressure
    issue(8'h33, 8'd3, 16'hABCD, 0, t);
    at_cyc(t);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_ready_low", 32'(req_ready), 32'd0);
    at_cyc(t + 3);
    check_val("t1_done_early", 32'(pkt_done), 32'd0);
    at_cyc(t + 4);
    check_val("t1_pkt_done", 32'(pkt_done), 32'd1);
    check_val("t1_ready_back", 32'(req_ready), 32'd1);
    check_val("t1_busy_clear", 32'(busy), 32'd0);
    at_cyc(t + 5);
    check_val("t1_done_pulse", 32'(pkt_done), 32'd0);
    check_val("t1_pkt_count", 32'(pkt_count), StatsEn ? 32'd1 : 32'd0);
    check_val("t1_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Header-only packet
    issue(8'h01, 8'd0, 16'h1234, 0, t);
    at_cyc(t + 1);
    check_val("t2_pkt_done", 32'(pkt_done), 32'd1);
    check_val("t2_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Backpressure for two cycles after the header, payload wraps
    issue(8'h45, 8'd3, 16'hFFFE, 2, t);
    @(posedge clk); #1;
    buffer_full = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    buffer_full = 1'b0;
    at_cyc(t + 6);
    check_val("t3_pkt_done", 32'(pkt_done), 32'd1);
    check_val("t3_stall_count", 32'(stall_count), StatsEn ? 32'd2 : 32'd0);
    check_val("t3_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Self-addressed request is dropped
    issue(LocalAddr, 8'd4, 16'h0000, 0, t);
    at_cyc(t);
    check_val("t4_req_err", 32'(req_err), 32'd1);
    check_val("t4_busy", 32'(busy), 32'd0);
    check_val("t4_ready", 32'(req_ready), 32'd1);
    at_cyc(t + 1);
    check_val("t4_err_pulse", 32'(req_err), 32'd0);
    check_val("t4_busy_later", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Reset after two body flits of a length-5 packet
    issue(8'h77, 8'd5, 16'h1000, 0, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    at_cyc(t + 3);
    check_val("t5_ready", 32'(req_ready), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_data_zero", 32'(data_out), 32'd0);
    check_val("t5_pkt_count", 32'(pkt_count), 32'd0);
    check_val("t5_stall_count", 32'(stall_count), 32'd0);
    check_val("t5_abandoned", 32'(sb.size()), 32'd3);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(8'h23, 8'd1, 16'h5555, 0, t);
    at_cyc(t + 2);
    check_val("t5_new_done", 32'(pkt_done), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back single-body packets
    issue(8'h34, 8'd1, 16'h0001, 0, t);
    issue(8'h45, 8'd1, 16'h0100, 0, t2);
    check_val("t6_gap", 32'(t2 - t), 32'd3);
    at_cyc(t2 + 2);
    check_val("t6_pkt_done", 32'(pkt_done), 32'd1);
    at_cyc(t2 + 3);
    check_val("t6_pkt_count", 32'(pkt_count), StatsEn ? 32'd2 : 32'd0);
    check_val("t6_sb_empty", 32'(sb.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/local_packet_source.md
# local_packet_source

Local-node traffic injector that drives the local port of a mesh router node. It accepts a packet descriptor from the test or core side and emits one header flit, {length, dest}, followed by `length` body flits. It uses the same flit-level handshake the router's input FIFOs use: `sending_data` is asserted only while `buffer_full` is low. It is the transmitting end of the node link and feeds the router's local input buffer and address counter.

## Interface
Parameters:
- NODE_X, 0, X coordinate of this node; forms LOCAL_ADDR[7:4] = NODE_X[3:0].
- NODE_Y, 0, Y coordinate of this node; forms LOCAL_ADDR[3:0] = NODE_Y[3:0].
- MAX_LEN, 255, maximum body flits per packet (1..255); larger requests are clamped.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  descriptor accepted when req_valid & req_ready.
- req_dest  in  8  destination address {x[3:0], y[3:0]}.
- req_length  in  8  body flit count; 0 means a header-only packet.
- req_seed  in  16  payload of body flit 0; flit i = req_seed + i, mod 2^16.
- buffer_full  in  1  router local input FIFO full.
- sending_data  out  1  flit on data_out transfers this cycle.
- data_out  out  16  flit; 16'h0000 whenever sending_data = 0.
- busy  out  1  packet in progress (state != IDLE).
- pkt_done  out  1  one-cycle pulse after the last flit of a packet transfers.
- req_err  out  1  one-cycle pulse when a self-addressed request is dropped.
- pkt_count  out  16  packets completed (see Configuration).
- stall_count  out  16  backpressure cycles (see Configuration).

## Operation
- State machine with three states: IDLE, HEAD, BODY. Registers: dest_q[7:0], len_q[7:0], remain_q[7:0], payload_q[15:0].
- IDLE:
  - req_ready = 1.
  - On acceptance, latch dest, len = min(req_length, MAX_LEN), and payload = req_seed.
  - If req_dest == LOCAL_ADDR: pulse req_err next cycle, stay in IDLE, and emit nothing.
  - Otherwise go to HEAD.
- HEAD:
  - data_out = {len_q, dest_q}; sending_data = !buffer_full.
  - On transfer with len_q == 0: go to IDLE and pulse pkt_done.
  - On transfer with len_q != 0: go to BODY, remain_q = len_q.
- BODY:
  - data_out = payload_q; sending_data = !buffer_full.
  - On transfer: payload_q += 1 (wraps 16'hFFFF to 16'h0000) and remain_q -= 1.
  - When the transfer happens with remain_q == 1: go to IDLE and pulse pkt_done.
- sending_data is combinational from state and buffer_full. No flit is ever presented while buffer_full = 1.
- Only IDLE accepts requests. req_valid outside IDLE is ignored; the descriptor is held by the requester.
- Reset mid-packet:
  - State goes to IDLE, and all registers and pulses clear.
  - The partial packet is abandoned; the receiver-side length tracker must also be reset.

## Timing
- Reset values:
  - req_ready = 1.
  - sending_data, busy, pkt_done, req_err = 0.
  - data_out, pkt_count, stall_count = 16'h0000.
- Request accepted at edge T: header is presented in cycle T+1.
- With no backpressure, body flit i transfers in cycle T+2+i.
- pkt_done and req_ready assert together in the cycle after the last transfer. The next header appears no earlier than 2 cycles after the last flit, giving one bubble between packets.
- Each cycle with buffer_full = 1 in HEAD or BODY delays the remaining flits by exactly one cycle. data_out holds 16'h0000 during the stall, and flit content resumes unchanged.
- req_err: pulses in cycle T+1; req_ready stays 1.
- Simultaneous buffer_full deassertion and the final flit: the transfer counts, and pkt_done follows on the next cycle.

## Configuration
- Macro: LOCAL_PACKET_SOURCE_STATS_EN.
- Defined:
  - pkt_count increments on each pkt_done.
  - stall_count increments on each cycle in HEAD or BODY with buffer_full = 1.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: the ports remain, are tied to 16'h0000, and the counter logic is absent.

## Test plan
- Node (1,2), request dest 8'h33, length 3, seed 16'hABCD, buffer_full = 0. Required flits: 16'h0333, 16'hABCD, 16'hABCE, 16'hABCF on consecutive cycles starting at T+1; pkt_done at T+5.
- Request length 0, dest 8'h01. Required: single flit 16'h0001, then pkt_done; no body flits.
- Seed 16'hFFFE, length 3, with buffer_full high for 2 cycles after the header. Required: sending_data low during the stall; body 16'hFFFE, 16'hFFFF, 16'h0000; stall_count = 2 when the macro is defined.
- Node (1,2), request dest 8'h12. Required: req_err pulse at T+1, no sending_data, busy stays 0.
- Assert rst after 2 body flits of a length-5 packet. Required: next cycle IDLE, req_ready = 1, data_out = 0; a new request starts with a fresh header.
- Back-to-back requests, length 1 each. Required: gap of exactly one cycle between the last body flit and the next header; pkt_count = 2.
